// File: rtl/reg_ctx_mover.sv
// reg_ctx_mover: context save/restore engine.
// On a start command it moves all 2**pw registers into a contiguous data-memory
// window (save, dir=0) or reloads them from that window (restore, dir=1). While
// busy it owns the register-file write port, the register-file read address and
// the data-memory port. It signals completion with a one-cycle done pulse.
//
// Ports
//   clk, rst_n       clock and asynchronous active-low reset
//   start, dir       command request and direction; sampled only in idle
//   base_addr        first memory address of the window; sampled with start
//   busy, done       transfer in progress / one-cycle completion pulse
//   rf_*             register-file initiator side (address, write enables, data)
//   mem_*            data-memory initiator side; mem_rd_data lags mem_addr by one cycle
//
// state      | meaning
// -----------+-------------------------------------------------------------
// st_idle    | no transfer; all outputs 0; accepts start (also in the done cycle)
// st_save    | one register per cycle: rf_addr=i -> mem[base+i]
// st_restore | pipelined: issue mem[base+i], write reg i-1 from the read data
module reg_ctx_mover #(
  parameter int pw = 4,
  parameter int aw = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dir,
  input  logic [aw-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic [pw:0]   rf_addr,
  output logic          rf_imm_val,
  output logic          rf_acc_write,
  output logic          rf_reg_write,
  output logic [7:0]    rf_dat_out,
  input  logic [7:0]    rf_reg_in,
  output logic [aw-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data
);

  localparam logic [pw:0] last_idx = (pw+1)'((1 << pw) - 1);
  localparam logic [pw:0] n_regs   = (pw+1)'(1 << pw);

  typedef enum logic [1:0] {
    st_idle,
    st_save,
    st_restore
  } state_t;

  state_t        state_q, state_d;
  logic [pw:0]   idx_q, idx_d;
  logic [aw-1:0] base_q;
  logic          done_q, done_d;
  logic [pw:0]   wr_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= st_idle;
      idx_q   <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (state_q == st_idle && start) begin
        base_q <= base_addr;
      end
    end
  end

  // Outputs decode only registered state and the index, so nothing here
  // depends combinationally on start.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    busy         = 1'b0;
    rf_addr      = '0;
    rf_imm_val   = 1'b0;
    rf_acc_write = 1'b0;
    rf_reg_write = 1'b0;
    rf_dat_out   = '0;
    mem_addr     = '0;
    mem_wr_en    = 1'b0;
    mem_wr_data  = '0;
    // restore writes lag the memory issue index by one
    wr_idx       = idx_q - 1'b1;

    case (state_q)
      st_idle: begin
        idx_d = '0;
        if (start) begin
          state_d = dir ? st_restore : st_save;
        end
      end

      st_save: begin
        busy        = 1'b1;
        rf_addr     = idx_q;
        mem_addr    = base_q + aw'(idx_q);
        mem_wr_en   = 1'b1;
        mem_wr_data = rf_reg_in;
        if (idx_q == last_idx) begin
          state_d = st_idle;
          done_d  = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      st_restore: begin
        busy = 1'b1;
        if (idx_q != n_regs) begin
          mem_addr = base_q + aw'(idx_q);
        end
        if (idx_q != '0) begin
          rf_addr    = wr_idx;
          rf_dat_out = mem_rd_data;
          if (wr_idx == '0) begin
            rf_acc_write = 1'b1;
          end else begin
            rf_reg_write = 1'b1;
          end
        end
        if (idx_q == n_regs) begin
          state_d = st_idle;
          done_d  = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = st_idle;
        idx_d   = '0;
      end
    endcase

    done = done_q;
  end

endmodule

// File: tb/tb_reg_ctx_mover.sv
// tb_reg_ctx_mover: self-checking bench for reg_ctx_mover.
// Provides a behavioural register file and data memory attached to the DUT, and
// keeps an independent expected image of both that is updated per command from
// the transfer rules (save: mem[base+k]=reg[k]; restore: reg[k]=mem[base+k]).
module tb_reg_ctx_mover;
  localparam int pw = 4;
  localparam int aw = 8;
  localparam int nr = 1 << pw;
  localparam int nm = 1 << aw;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic [aw-1:0] base_addr = '0;
  logic          busy, done;
  logic [pw:0]   rf_addr;
  logic          rf_imm_val, rf_acc_write, rf_reg_write;
  logic [7:0]    rf_dat_out, rf_reg_in;
  logic [aw-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data, mem_rd_data;

  logic [7:0] mem [nm];
  logic [7:0] regs [nr];
  logic [7:0] init_mem [nm];
  logic [7:0] init_regs [nr];
  logic [7:0] exp_mem [nm];
  logic [7:0] exp_regs [nr];
  logic       load_req = 1'b0;
  logic [7:0] rd_q;

  int n_checks = 0;
  int n_fail = 0;

  reg_ctx_mover #(.pw(pw), .aw(aw)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .base_addr(base_addr),
    .busy(busy), .done(done), .rf_addr(rf_addr), .rf_imm_val(rf_imm_val),
    .rf_acc_write(rf_acc_write), .rf_reg_write(rf_reg_write),
    .rf_dat_out(rf_dat_out), .rf_reg_in(rf_reg_in), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  assign rf_reg_in   = regs[rf_addr[pw-1:0]];
  assign mem_rd_data = rd_q;

  always @(posedge clk) begin
    if (load_req) begin
      mem  <= init_mem;
      regs <= init_regs;
    end else begin
      if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
      if (rf_acc_write) regs[0] <= rf_dat_out;
      if (rf_reg_write) regs[rf_addr[pw-1:0]] <= rf_dat_out;
    end
    rd_q <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_model();
    init_mem  = exp_mem;
    init_regs = exp_regs;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < nm; k++) check($sformatf("%s_mem[%0h]", tag, k), mem[k], exp_mem[k]);
    for (int k = 0; k < nr; k++) check($sformatf("%s_reg[%0d]", tag, k), regs[k], exp_regs[k]);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {busy, done, rf_imm_val, rf_acc_write, rf_reg_write, mem_wr_en, rf_addr}, 0);
    check({tag, "_data"}, {rf_dat_out, mem_wr_data, mem_addr}, 0);
  endtask

  // One command from idle; repulse >= 0 re-asserts start (opposite dir, base 0)
  // in that busy cycle, which must be ignored.
  task automatic do_cmd(input bit d, input logic [7:0] b, input int repulse, input string tag);
    int len, nbusy, ndone, done_at, nacc, acc_at, nregw, nmemw, addr_err, bad;
    len = d ? nr + 1 : nr;
    nbusy = 0; ndone = 0; done_at = -1; nacc = 0; acc_at = -1;
    nregw = 0; nmemw = 0; addr_err = 0; bad = 0;
    @(negedge clk);
    start = 1'b1; dir = d; base_addr = b;
    @(negedge clk);
    start = 1'b0; dir = ~d; base_addr = 8'($urandom);
    for (int c = 0; c < len + 6; c++) begin
      if (busy) nbusy++;
      if (busy !== (c < len)) bad++;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (done && busy) bad++;
      if (rf_acc_write) begin nacc++; acc_at = c; end
      if (rf_reg_write) nregw++;
      if (rf_reg_write && rf_addr[pw-1:0] == 0) bad++;
      if (rf_acc_write && rf_reg_write) bad++;
      if (rf_addr[pw] !== 1'b0 || rf_imm_val !== 1'b0) bad++;
      if (mem_wr_en) nmemw++;
      if (c < nr && mem_addr !== 8'(b + c)) addr_err++;
      if (!busy && (mem_wr_en || rf_acc_write || rf_reg_write || mem_addr !== 0 || rf_addr !== 0)) bad++;
      if (c == repulse) begin
        start = 1'b1; dir = ~d; base_addr = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_len"}, nbusy, len);
    check({tag, "_done_at"}, done_at, len);
    check({tag, "_done_cnt"}, ndone, 1);
    check({tag, "_acc_cnt"}, nacc, d ? 1 : 0);
    if (d) check({tag, "_acc_at"}, acc_at, 1);
    check({tag, "_regw_cnt"}, nregw, d ? nr - 1 : 0);
    check({tag, "_memw_cnt"}, nmemw, d ? 0 : nr);
    check({tag, "_addr_seq"}, addr_err, 0);
    check({tag, "_protocol"}, bad, 0);
    for (int k = 0; k < nr; k++) begin
      if (d) exp_regs[k] = exp_mem[8'(b + k)];
      else   exp_mem[8'(b + k)] = exp_regs[k];
    end
    compare_all(tag);
  endtask

  initial begin
    logic [7:0] b;
    int nw, d1, d2, extra, nb;

    for (int k = 0; k < nm; k++) exp_mem[k] = 8'($urandom);
    for (int k = 0; k < nr; k++) exp_regs[k] = 8'($urandom);

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    load_model();

    // save, base 0x40, regs 0x10+i
    for (int k = 0; k < nr; k++) exp_regs[k] = 8'(8'h10 + k);
    load_model();
    do_cmd(1'b0, 8'h40, -1, "save40");

    // restore, base 0x20, mem 0xA0+i
    for (int k = 0; k < nr; k++) exp_mem[8'h20 + k] = 8'(8'hA0 + k);
    load_model();
    do_cmd(1'b1, 8'h20, -1, "rest20");

    // restore across the top of memory
    for (int k = 0; k < nr; k++) exp_mem[8'(8'hF8 + k)] = 8'($urandom);
    load_model();
    do_cmd(1'b1, 8'hF8, -1, "restF8");

    // start re-pulsed during a save is ignored
    for (int k = 0; k < nr; k++) exp_regs[k] = 8'($urandom);
    load_model();
    do_cmd(1'b0, 8'h80, 4, "repulse");

    // reset after the fifth save write
    for (int k = 0; k < nr; k++) exp_regs[k] = 8'($urandom);
    load_model();
    b = 8'h90;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; base_addr = b;
    @(negedge clk);
    start = 1'b0;
    nw = 0;
    for (int c = 0; c < 40 && nw < 5; c++) begin
      if (mem_wr_en) nw++;
      @(negedge clk);
    end
    check("rst_write_cnt", nw, 5);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    for (int k = 0; k < 5; k++) exp_mem[8'(b + k)] = exp_regs[k];
    repeat (2) @(negedge clk);
    check_outputs_zero("midrst_hold");
    rst_n = 1'b1;
    compare_all("midrst");
    do_cmd(1'b1, 8'h90, -1, "after_rst");

    // start held through the done cycle: back-to-back saves
    for (int k = 0; k < nr; k++) exp_regs[k] = 8'($urandom);
    load_model();
    b = 8'h33;
    @(negedge clk);
    start = 1'b1; dir = 1'b0; base_addr = b;
    d1 = -1; d2 = -1; extra = 0; nb = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
        else extra++;
      end
      if (d1 >= 0 && c > d1) start = 1'b0;
    end
    start = 1'b0;
    check("b2b_first_done", d1, nr);
    check("b2b_spacing", d2 - d1, nr + 1);
    check("b2b_extra_done", extra, 0);
    check("b2b_busy", nb, 2 * nr);
    for (int k = 0; k < nr; k++) exp_mem[8'(b + k)] = exp_regs[k];
    compare_all("b2b");

    // randomized commands
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < nm; k++) if ($urandom_range(0, 3) == 0) exp_mem[k] = 8'($urandom);
      for (int k = 0; k < nr; k++) exp_regs[k] = 8'($urandom);
      load_model();
      do_cmd(1'($urandom_range(0, 1)), 8'($urandom), -1, $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_ctx_mover.md
# reg_ctx_mover

Context save/restore engine that drives the register file's write port and read address as its initiator. On command it copies all 2**pw registers to a contiguous data-memory window (save) or reloads them from that window (restore). It sits beside the controller, takes over the register-file and data-memory ports while busy, and returns control with a one-cycle done pulse.

## Interface
- pw, 4, register pointer width; 2**pw registers moved per command
- aw, 8, data-memory address width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command request; sampled only in IDLE
- dir  in  1  0 = save (regs → mem), 1 = restore (mem → regs); sampled with start
- base_addr  in  aw  first memory address; sampled with start
- busy  out  1  transfer in progress; the controller must not drive the reg file or memory while high
- done  out  1  one-cycle pulse on completion
- rf_addr  out  pw+1  register-file address; MSB always 0
- rf_imm_val  out  1  register-file immediate-select; constant 0 so rf_reg_in returns register contents
- rf_acc_write  out  1  accumulator write enable; index 0 only
- rf_reg_write  out  1  register write enable; indices 1..2**pw-1
- rf_dat_out  out  8  register-file write data
- rf_reg_in  in  8  register-file read data; combinational from rf_addr
- mem_addr  out  aw  data-memory address
- mem_wr_en  out  1  data-memory write enable
- mem_wr_data  out  8  data-memory write data
- mem_rd_data  in  8  data-memory read data; valid one cycle after mem_addr is presented

## Operation
- States: IDLE, SAVE, RESTORE.
- IDLE:
  - All enables are 0.
  - On start=1, latch dir and base_addr, clear index counter i (pw+1 bits), then go to SAVE or RESTORE.
- SAVE, one register per cycle:
  - rf_addr=i, mem_addr=base+i, mem_wr_data=rf_reg_in, mem_wr_en=1.
  - After i=2**pw-1, return to IDLE and pulse done.
- RESTORE is pipelined, with issue index i and write index i-1:
  - Cycle with i=0: mem_addr=base, no register write.
  - Each following cycle: rf_addr=i-1, rf_dat_out=mem_rd_data, write enable asserted. While i<2**pw, it also issues mem_addr=base+i.
  - After the write of index 2**pw-1, return to IDLE and pulse done.
- Write-enable selection:
  - Index 0 uses rf_acc_write. All other indices use rf_reg_write.
  - The two are never high in the same cycle.
- Address arithmetic: base+i is taken modulo 2**aw, so it wraps from 2**aw-1 to 0 with no error.
- A start pulse while busy=1 is ignored, and dir and base_addr are not re-sampled.
- The memory is never read during SAVE and never written during RESTORE.
- Reset, at any time including mid-transfer:
  - Return to IDLE at once.
  - Counters clear.
  - Pending writes are abandoned; already-written locations keep their values.
- Reset values: busy=0, done=0, rf_addr=0, rf_imm_val=0, rf_acc_write=0, rf_reg_write=0, rf_dat_out=0, mem_addr=0, mem_wr_en=0, mem_wr_data=0.
- In IDLE, data and address outputs hold 0.

## Timing
- start is sampled at edge E0.
- busy is high from the cycle after E0:
  - save: exactly 2**pw cycles (16 at default)
  - restore: exactly 2**pw+1 cycles (17 at default)
- done is high for exactly the first cycle after busy falls, with busy=0 in that cycle.
- A start asserted during the done cycle is accepted, because the block is in IDLE. Back-to-back commands therefore have one idle/done cycle between them.
- busy and the write enables are registered state decodes; no combinational path from start.
- mem_rd_data is captured the cycle after its address is issued; the block has no other read latency assumption.

## Test plan
- Save, base=0x40, regs preloaded with 0x10+i:
  - mem[0x40..0x4F] must equal 0x10..0x1F.
  - busy=16 cycles, then done pulses once.
  - rf_acc_write is never set.
- Restore, base=0x20, mem[0x20+i]=0xA0+i:
  - reg i must equal 0xA0+i.
  - rf_acc_write is high only on the index-0 write.
  - busy=17 cycles.
- Restore, base=0xF8:
  - mem_addr sequence must be F8..FF,00..07.
  - regs 8..15 are loaded from mem[0x00..0x07].
- start re-pulsed at cycle 5 of a save with dir=1, base=0x00:
  - Ignored; the save completes to its original base.
  - Exactly one done.
- rst_n low after the 5th save write:
  - All outputs 0 within the reset.
  - mem[base+0..4] are written, mem[base+5..] are unchanged.
  - After release, a new start runs a full transfer.
- Start held high through the done cycle:
  - A second transfer begins immediately.
  - Two done pulses, separated by the full busy length plus 1.
